apb_master_nslv: RTL
====================

# apb_master_nslv

Parametrised APB4 master bridge between the CPU load/store path and a configurable number of memory-mapped peripherals. It latches a single request from the internal interface and decodes the target slave from a base address and a fixed per-slave window. It then runs the APB SETUP/ACCESS sequence with PSTRB, and returns read data and an error flag through a registered one-cycle response. Unmapped addresses, slave-signalled errors (PSLVERR) and hung slaves (timeout) all complete with an error instead of stalling the CPU.

## Interface
- NUM_SLV, 4, number of APB slaves (1..16); IDX_W = max(1, clog2(NUM_SLV))
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8); STRB_W = DATA_W/8
- BASE_ADDR, 32'h1000_0000, start of slave 0 window
- WIN_BITS, 12, log2 of each slave window size in bytes (slave k spans BASE_ADDR + k·2^WIN_BITS)
- TIMEOUT, 16, max ACCESS cycles without PREADY before forced error; 0 disables timeout
- PCLK  in  1  clock, rising edge
- PRESET  in  1  reset, asynchronous, active-high
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PENABLE  out  1  APB access phase
- PWDATA  out  DATA_W  APB write data
- PSTRB  out  STRB_W  APB write byte strobes
- PSEL  out  NUM_SLV  one-hot slave select
- PRDATA  in  NUM_SLV·DATA_W  flattened slave read data, slave k at [k·DATA_W +: DATA_W]
- PREADY  in  NUM_SLV  per-slave ready
- PSLVERR  in  NUM_SLV  per-slave error
- transfer  in  1  request strobe, sampled only in IDLE
- write  in  1  1 = write, 0 = read
- addr  in  ADDR_W  request address
- wdata  in  DATA_W  request write data
- strb  in  STRB_W  request byte enables
- busy  out  1  high whenever state ≠ IDLE
- ready  out  1  one-cycle response pulse
- rdata  out  DATA_W  read data, valid with ready
- error  out  1  error flag, valid with ready

## Operation
- States: IDLE, SETUP, ACCESS, DECERR.
- IDLE with transfer=1:
  - Latch addr, write, wdata and strb. On reads the latched strb is forced to 0.
  - Decode: hit when BASE_ADDR ≤ addr < BASE_ADDR + NUM_SLV·2^WIN_BITS. Index = (addr − BASE_ADDR) >> WIN_BITS, latched into an IDX_W register.
  - Hit → SETUP. Miss → DECERR.
- In any state other than IDLE, transfer is ignored. No request queuing.
- SETUP: PSEL[idx]=1, PENABLE=0. Clear the timeout counter. Go to ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1. PREADY[idx] and PSLVERR[idx] are muxed by the latched index.
  - PREADY[idx]=1 → IDLE. Register ready=1 and error=PSLVERR[idx]. Register rdata=PRDATA[idx] on reads; rdata=0 on writes or when PSLVERR=1.
  - PREADY[idx]=0 with TIMEOUT≠0 and counter = TIMEOUT−1 → IDLE with ready=1, error=1, rdata=0. PSEL and PENABLE drop on the same edge.
  - Otherwise, increment the counter and stay in ACCESS.
- DECERR: no PSEL asserted and no bus activity. Go to IDLE with ready=1, error=1, rdata=0.
- PADDR, PWRITE, PWDATA and PSTRB always drive the latched values and hold them until the next accepted request.
- The PSEL bits of non-selected slaves are always 0. PENABLE is never 1 without a PSEL.
- ready and error are 0 in every cycle except the response cycle. rdata holds its last value between responses.

## Timing
- Reset (asynchronous, immediate) drives:
  - state=IDLE
  - PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0
  - busy=0, ready=0, error=0, rdata=0, counter=0
- Reset mid-transfer aborts with no ready pulse.
- transfer is accepted at edge E0. SETUP runs in cycle E0→E1 and ACCESS starts at E1.
  - With zero wait states, ready is high in cycle E2→E3.
  - Minimum request-to-response latency is 3 cycles. Each wait state adds 1 cycle.
- Decode miss: ready/error pulse 2 cycles after acceptance.
- Timeout: ACCESS lasts exactly TIMEOUT cycles, then ready/error pulses in the next cycle.
- busy rises the cycle after acceptance. It is low in the ready cycle, so a new transfer may be presented in the ready cycle itself.
- PREADY of non-selected slaves and PRDATA outside the completing cycle are don't-care.

## Test plan
- Write 0x1000_2004, wdata 0xDEAD_BEEF, strb 4'b0011, PREADY2 tied 1:
  - PSEL=4'b0100 for 2 cycles, PENABLE high in the 2nd, PSTRB=4'b0011.
  - ready 3 cycles after transfer, error=0.
- Read 0x1000_1010, PREADY1 low for 2 ACCESS cycles, PRDATA1=0x1234_5678:
  - ACCESS lasts 3 cycles, PSTRB=0.
  - ready at acceptance+5 with rdata=0x1234_5678, error=0.
- Read 0x2000_0000 (unmapped):
  - PSEL stays 0.
  - ready and error at acceptance+2, rdata=0.
- Read 0x1000_3000 with PREADY3 held 0, TIMEOUT=16:
  - ACCESS lasts exactly 16 cycles, then PSEL=0.
  - ready=1, error=1, rdata=0.
- Write to slave 0 completing with PSLVERR0=1 → error=1 with ready. Then assert a second transfer while busy → it is ignored, and no second bus cycle occurs.
- Assert PRESET asynchronously mid-ACCESS → PSEL, PENABLE and busy go 0 immediately, and no ready pulse follows.
- After reset release, a read of 0x1000_0000 completes normally.

Source files
------------

// File: rtl/apb_master_nslv.sv
// APB4 master bridge: latches one CPU request, decodes a slave window,
// runs SETUP/ACCESS and returns a registered one-cycle response.
module apb_master_nslv #(
  parameter int                NUM_SLV   = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1000_0000,
  parameter int                WIN_BITS  = 12,
  parameter int                TIMEOUT   = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [DATA_W/8-1:0]       PSTRB,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
  input  logic                      transfer,
  input  logic                      write,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       strb,
  output logic                      busy,
  output logic                      ready,
  output logic [DATA_W-1:0]         rdata,
  output logic                      error
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] slot;
  logic              hit;
  logic              sel_ready;
  logic              sel_err;
  logic [DATA_W-1:0] sel_rdata;
  logic              tmo;

  // Offset is only meaningful when addr >= BASE_ADDR; hit guards that.
  assign off  = addr - BASE_ADDR;
  assign slot = off >> WIN_BITS;
  assign hit  = (addr >= BASE_ADDR) &&
                (slot < ADDR_W'(NUM_SLV));

  assign sel_ready = PREADY[idx];
  assign sel_err   = PSLVERR[idx];
  assign sel_rdata = PRDATA[idx*DATA_W +: DATA_W];

  assign tmo = (TIMEOUT != 0) &&
               (cnt == CNT_W'(TIMEOUT - 1));

  assign PENABLE = (state == ACCESS);
  assign busy    = (state != IDLE);

  always_comb begin
    PSEL = '0;
    if (state == SETUP || state == ACCESS)
      PSEL[idx] = 1'b1;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB  <= '0;
      ready  <= 1'b0;
      error  <= 1'b0;
      rdata  <= '0;
    end else begin
      ready <= 1'b0;
      error <= 1'b0;
      unique case (1'b1)
        state == IDLE: begin
          if (transfer) begin
            PADDR  <= addr;
            PWRITE <= write;
            PWDATA <= wdata;
            PSTRB  <= write ? strb : '0;
            idx    <= slot[IDX_W-1:0];
            state  <= hit ? SETUP : DECERR;
          end
        end
        state == SETUP: begin
          cnt   <= '0;
          state <= ACCESS;
        end
        state == ACCESS: begin
          if (sel_ready) begin
            state <= IDLE;
            ready <= 1'b1;
            error <= sel_err;
            rdata <= (!PWRITE && !sel_err)
                     ? sel_rdata : '0;
          end else if (tmo) begin
            state <= IDLE;
            ready <= 1'b1;
            error <= 1'b1;
            rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        state == DECERR: begin
          state <= IDLE;
          ready <= 1'b1;
          error <= 1'b1;
          rdata <= '0;
        end
      endcase
    end
  end

endmodule
